// File: rtl/atm_input_pkg.sv
// Shared types and constants for the ATM keyboard-entry path: FSM states,
// status/mode encodings, control characters and the menu code set.
package atm_input_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_MENU,
      ST_FINISH
   } entry_state_e;

   // Menu codes are also decoded by the ATM main controller.
   typedef enum logic [2:0] {
      MENU_NONE     = 3'd0,
      MENU_BALANCE  = 3'd1,
      MENU_WITHDRAW = 3'd2,
      MENU_DEPOSIT  = 3'd3,
      MENU_TRANSFER = 3'd4,
      MENU_CURRENCY = 3'd5,
      MENU_EXIT     = 3'd6
   } menu_code_e;

   localparam logic [3:0] STATUS_OK        = 4'd0;
   localparam logic [3:0] STATUS_ILLEGAL   = 4'd1;
   localparam logic [3:0] STATUS_OVERFLOW  = 4'd2;
   localparam logic [3:0] STATUS_EMPTY     = 4'd3;
   localparam logic [3:0] STATUS_CANCELLED = 4'd4;
   localparam logic [3:0] STATUS_TIMEOUT   = 4'd5;

   localparam logic [1:0] MODE_NONE    = 2'b00;
   localparam logic [1:0] MODE_NUMERIC = 2'b01;
   localparam logic [1:0] MODE_MENU    = 2'b10;
   localparam logic [1:0] MODE_MASKED  = 2'b11;

   localparam logic [7:0] ASCII_BS   = 8'h08;
   localparam logic [7:0] ASCII_CR   = 8'h0D;
   localparam logic [7:0] ASCII_ESC  = 8'h1B;
   localparam logic [7:0] ASCII_STAR = 8'h2A;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_9    = 8'h39;

   function automatic logic is_digit(input logic [7:0] code);
      return (code >= ASCII_0) && (code <= ASCII_9);
   endfunction

   // Setting bit 5 folds upper-case letters onto lower case; only the two
   // case variants of each menu letter can land on these values.
   function automatic menu_code_e menu_decode(input logic [7:0] code);
      logic [7:0] w_lower;
      w_lower = code | 8'h20;
      case (w_lower)
         8'h62:   return MENU_BALANCE;
         8'h77:   return MENU_WITHDRAW;
         8'h64:   return MENU_DEPOSIT;
         8'h74:   return MENU_TRANSFER;
         8'h63:   return MENU_CURRENCY;
         8'h78:   return MENU_EXIT;
         default: return MENU_NONE;
      endcase
   endfunction

endpackage

// File: rtl/atm_timeout_ctr.sv
// Inactivity down-counter: clear reloads TIMEOUT-1, enable counts toward zero,
// expired is high while the count sits at zero.
module atm_timeout_ctr #(
   parameter int TIMEOUT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = $clog2(TIMEOUT);
   localparam logic [TW-1:0] LOAD = TW'(TIMEOUT - 1);

   logic [TW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= LOAD;
      end else if (enable && (r_cnt != '0)) begin
         r_cnt <= r_cnt - TW'(1);
      end
   end

   assign expired = (r_cnt == '0);

endmodule

// File: rtl/atm_key_entry.sv
// Keyboard-entry engine: assembles packed-BCD numeric fields or a single menu
// selection from ASCII key strobes, with backspace, cancel, masking and timeout.
module atm_key_entry
   import atm_input_pkg::*;
#(
   parameter int MAX_DIGITS = 4,
   parameter int VALUE_W    = 16,
   parameter int TIMEOUT    = 1_000_000
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [7:0]                       ascii_code,
   input  logic                             ready,
   input  logic                             start,
   input  logic [1:0]                       mode,
   output logic [VALUE_W-1:0]               value,
   output logic [$clog2(MAX_DIGITS+1)-1:0]  digit_count,
   output logic [2:0]                       menu_sel,
   output logic                             busy,
   output logic                             done,
   output logic [3:0]                       status,
   output logic                             echo_valid,
   output logic [7:0]                       echo_char
);

   localparam int CW = $clog2(MAX_DIGITS + 1);
   localparam logic [CW-1:0] FULL = CW'(MAX_DIGITS);

   entry_state_e       r_state;
   logic [VALUE_W-1:0] r_value;
   logic [CW-1:0]      r_count;
   menu_code_e         r_menu_sel;
   logic               r_busy;
   logic               r_done;
   logic [3:0]         r_status;
   logic               r_echo_valid;
   logic [7:0]         r_echo_char;
   logic               r_masked;

   logic       w_start_ok;
   logic       w_in_entry;
   logic       w_tmr_clear;
   logic       w_expired;
   logic       w_is_digit;
   logic       w_has_digits;
   menu_code_e w_menu_key;

   assign w_start_ok   = start && (mode != MODE_NONE);
   assign w_in_entry   = (r_state == ST_COLLECT) || (r_state == ST_MENU);
   assign w_tmr_clear  = w_start_ok || (ready && w_in_entry);
   assign w_is_digit   = is_digit(ascii_code);
   assign w_has_digits = (r_count != '0);
   assign w_menu_key   = menu_decode(ascii_code);

   atm_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (w_tmr_clear),
      .enable  (w_in_entry),
      .expired (w_expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_value      <= '0;
         r_count      <= '0;
         r_menu_sel   <= MENU_NONE;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_status     <= STATUS_OK;
         r_echo_valid <= 1'b0;
         r_echo_char  <= '0;
         r_masked     <= 1'b0;
      end else begin
         r_done       <= 1'b0;
         r_echo_valid <= 1'b0;
         // An accepted start outranks any key or timeout on the same edge.
         if (w_start_ok) begin
            r_busy   <= 1'b1;
            r_status <= STATUS_OK;
            r_masked <= (mode == MODE_MASKED);
            if (mode == MODE_MENU) begin
               r_state    <= ST_MENU;
               r_menu_sel <= MENU_NONE;
            end else begin
               r_state <= ST_COLLECT;
               r_value <= '0;
               r_count <= '0;
            end
         end else begin
            case (r_state)
               ST_COLLECT: begin
                  if (ready) begin
                     if (w_is_digit) begin
                        if (r_count != FULL) begin
                           r_value      <= VALUE_W'({r_value, ascii_code[3:0]});
                           r_count      <= r_count + CW'(1);
                           r_echo_valid <= 1'b1;
                           r_echo_char  <= r_masked ? ASCII_STAR : ascii_code;
                           r_status     <= STATUS_OK;
                        end else begin
                           r_status <= STATUS_OVERFLOW;
                        end
                     end else if (ascii_code == ASCII_BS) begin
                        if (w_has_digits) begin
                           r_value      <= r_value >> 4;
                           r_count      <= r_count - CW'(1);
                           r_echo_valid <= 1'b1;
                           r_echo_char  <= ASCII_BS;
                        end
                     end else if (ascii_code == ASCII_CR) begin
                        if (w_has_digits) begin
                           r_state  <= ST_FINISH;
                           r_done   <= 1'b1;
                           r_status <= STATUS_OK;
                        end else begin
                           r_status <= STATUS_EMPTY;
                        end
                     end else if (ascii_code == ASCII_ESC) begin
                        r_state  <= ST_FINISH;
                        r_done   <= 1'b1;
                        r_status <= STATUS_CANCELLED;
                        r_value  <= '0;
                        r_count  <= '0;
                     end else begin
                        r_status <= STATUS_ILLEGAL;
                     end
                  end else if (w_expired) begin
                     r_state  <= ST_FINISH;
                     r_done   <= 1'b1;
                     r_status <= STATUS_TIMEOUT;
                  end
               end

               ST_MENU: begin
                  if (ready) begin
                     if (w_menu_key != MENU_NONE) begin
                        r_menu_sel   <= w_menu_key;
                        r_echo_valid <= 1'b1;
                        r_echo_char  <= ascii_code;
                        r_status     <= STATUS_OK;
                     end else if (ascii_code == ASCII_CR) begin
                        if (r_menu_sel != MENU_NONE) begin
                           r_state  <= ST_FINISH;
                           r_done   <= 1'b1;
                           r_status <= STATUS_OK;
                        end else begin
                           r_status <= STATUS_EMPTY;
                        end
                     end else if (ascii_code == ASCII_ESC) begin
                        r_state    <= ST_FINISH;
                        r_done     <= 1'b1;
                        r_status   <= STATUS_CANCELLED;
                        r_menu_sel <= MENU_NONE;
                     end else begin
                        r_status <= STATUS_ILLEGAL;
                     end
                  end else if (w_expired) begin
                     r_state  <= ST_FINISH;
                     r_done   <= 1'b1;
                     r_status <= STATUS_TIMEOUT;
                  end
               end

               ST_FINISH: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign value       = r_value;
   assign digit_count = r_count;
   assign menu_sel    = r_menu_sel;
   assign busy        = r_busy;
   assign done        = r_done;
   assign status      = r_status;
   assign echo_valid  = r_echo_valid;
   assign echo_char   = r_echo_char;

endmodule

// File: tb/tb_atm_key_entry.sv
// Scoreboard bench for atm_key_entry: a per-cycle behavioural model predicts
// echoes, completions and visible state; a monitor matches DUT output pulses.
module tb_atm_key_entry;

   localparam int MAXD = 4;
   localparam int VW   = 16;
   localparam int TO   = 50;
   localparam int CW   = $clog2(MAXD + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    ascii_code = '0;
   logic          ready = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    mode = '0;
   logic [VW-1:0] value;
   logic [CW-1:0] digit_count;
   logic [2:0]    menu_sel;
   logic          busy;
   logic          done;
   logic [3:0]    status;
   logic          echo_valid;
   logic [7:0]    echo_char;

   atm_key_entry #(
      .MAX_DIGITS (MAXD),
      .VALUE_W    (VW),
      .TIMEOUT    (TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ascii_code  (ascii_code),
      .ready       (ready),
      .start       (start),
      .mode        (mode),
      .value       (value),
      .digit_count (digit_count),
      .menu_sel    (menu_sel),
      .busy        (busy),
      .done        (done),
      .status      (status),
      .echo_valid  (echo_valid),
      .echo_char   (echo_char)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int passes = 0;

   function automatic void check(string name, int act, int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
   endfunction

   typedef struct { int ch; int at; } echo_t;
   typedef struct { int val; int cnt; int msel; int st; int at; } done_t;
   echo_t exp_echo[$];
   done_t exp_done[$];

   // ---------------- reference model ----------------
   // m_state: 0 idle, 1 numeric, 2 menu, 3 finishing
   int m_state = 0;
   bit m_masked = 0;
   int m_dig[$];
   int m_msel = 0, m_status = 0, m_quiet = 0;

   function automatic int m_value();
      int v = 0;
      foreach (m_dig[i]) v = v * 16 + m_dig[i];
      return v;
   endfunction

   function automatic int menu_of(logic [7:0] c);
      logic [7:0] l;
      l = c;
      if (c >= "A" && c <= "Z") l = c + 8'd32;
      case (l)
         "b": return 1;
         "w": return 2;
         "d": return 3;
         "t": return 4;
         "c": return 5;
         "x": return 6;
         default: return 0;
      endcase
   endfunction

   function automatic void m_finish(int e);
      done_t d;
      m_state = 3;
      d.val = m_value(); d.cnt = m_dig.size(); d.msel = m_msel; d.st = m_status; d.at = e;
      exp_done.push_back(d);
   endfunction

   function automatic void m_echo(int ch, int e);
      echo_t x;
      x.ch = ch; x.at = e;
      exp_echo.push_back(x);
   endfunction

   function automatic void m_numeric_key(logic [7:0] c, int e);
      if (c >= "0" && c <= "9") begin
         if (m_dig.size() < MAXD) begin
            m_dig.push_back(int'(c) - 48);
            m_echo(m_masked ? 42 : int'(c), e);
            m_status = 0;
         end else m_status = 2;
      end else if (c == 8'h08) begin
         if (m_dig.size() > 0) begin
            void'(m_dig.pop_back());
            m_echo(8, e);
         end
      end else if (c == 8'h0D) begin
         if (m_dig.size() > 0) begin m_status = 0; m_finish(e); end
         else m_status = 3;
      end else if (c == 8'h1B) begin
         m_dig.delete(); m_status = 4; m_finish(e);
      end else m_status = 1;
   endfunction

   function automatic void m_menu_key(logic [7:0] c, int e);
      int sel = menu_of(c);
      if (sel != 0) begin
         m_msel = sel; m_status = 0; m_echo(int'(c), e);
      end else if (c == 8'h0D) begin
         if (m_msel != 0) begin m_status = 0; m_finish(e); end
         else m_status = 3;
      end else if (c == 8'h1B) begin
         m_msel = 0; m_status = 4; m_finish(e);
      end else m_status = 1;
   endfunction

   // Applies one clock edge (numbered e) of inputs to the model.
   function automatic void model_edge(bit st, logic [1:0] md, bit rd, logic [7:0] c, int e);
      if (st && md != 2'b00) begin
         m_quiet = 0; m_status = 0;
         if (md == 2'b10) begin m_state = 2; m_msel = 0; end
         else begin m_state = 1; m_masked = (md == 2'b11); m_dig.delete(); end
      end else if (m_state == 3) begin
         m_state = 0;
      end else if (m_state == 1 || m_state == 2) begin
         if (rd) begin
            m_quiet = 0;
            if (m_state == 1) m_numeric_key(c, e);
            else m_menu_key(c, e);
         end else begin
            m_quiet++;
            if (m_quiet == TO) begin m_status = 5; m_finish(e); end
         end
      end
   endfunction

   function automatic void model_reset();
      m_state = 0; m_masked = 0; m_dig.delete();
      m_msel = 0; m_status = 0; m_quiet = 0;
      exp_echo.delete(); exp_done.delete();
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (echo_valid) begin
         if (exp_echo.size() == 0) begin
            checks++;
            $display("FAIL echo_unexpected: got %02h, expected no echo (cycle %0d)", echo_char, cyc);
         end else begin
            echo_t x;
            x = exp_echo.pop_front();
            check("echo_char", int'(echo_char), x.ch);
            check("echo_cycle", cyc, x.at);
         end
      end
      if (done) begin
         if (exp_done.size() == 0) begin
            checks++;
            $display("FAIL done_unexpected: got done=1 status=%0d, expected no done (cycle %0d)", status, cyc);
         end else begin
            done_t d;
            d = exp_done.pop_front();
            check("done_cycle", cyc, d.at);
            check("done_value", int'(value), d.val);
            check("done_count", int'(digit_count), d.cnt);
            check("done_menu", int'(menu_sel), d.msel);
            check("done_status", int'(status), d.st);
         end
      end
   end

   // ---------------- driver ----------------
   task automatic check_state();
      check("value", int'(value), m_value());
      check("digit_count", int'(digit_count), m_dig.size());
      check("status", int'(status), m_status);
      check("menu_sel", int'(menu_sel), m_msel);
      check("busy", int'(busy), (m_state != 0) ? 1 : 0);
   endtask

   task automatic cyc_drive(bit st, logic [1:0] md, bit rd, logic [7:0] c);
      start = st; mode = md; ready = rd; ascii_code = c;
      model_edge(st, md, rd, c, cyc + 1);
      @(negedge clk);
      start = 1'b0; ready = 1'b0;
      check_state();
   endtask

   task automatic do_start(logic [1:0] md);
      cyc_drive(1'b1, md, 1'b0, 8'($urandom));
   endtask

   task automatic key(logic [7:0] c);
      cyc_drive(1'b0, 2'($urandom), 1'b1, c);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc_drive(1'b0, 2'($urandom), 1'b0, 8'($urandom));
   endtask

   function automatic logic [7:0] rand_key();
      logic [7:0] letters [12] = '{"b", "w", "d", "t", "c", "x", "B", "W", "D", "T", "C", "X"};
      int r = $urandom_range(0, 99);
      if (r < 40) return 8'(48 + $urandom_range(0, 9));
      if (r < 50) return 8'h08;
      if (r < 60) return 8'h0D;
      if (r < 65) return 8'h1B;
      if (r < 85) return letters[$urandom_range(0, 11)];
      return 8'($urandom);
   endfunction

   task automatic reset_mid_entry();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_value", int'(value), 0);
      check("rst_count", int'(digit_count), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_status", int'(status), 0);
      check("rst_echo", int'({echo_valid, echo_char}), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      check("reset_value", int'(value), 0);
      check("reset_outputs", int'({digit_count, menu_sel, busy, done, status, echo_valid, echo_char}), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // numeric entry with echoes
      key("5");
      do_start(2'b00);
      do_start(2'b01);
      key("1"); key("2"); key("3"); key("4"); key(8'h0D);
      check("tp_numeric_value", int'(value), 'h1234);
      check("tp_numeric_done", int'(done), 1);
      key("7");
      idle(2);

      // overflow, backspace, empty enter
      do_start(2'b01);
      key(8'h0D);
      key(8'h08);
      key("5"); key("6"); key("7"); key("8"); key("9");
      check("tp_overflow_status", int'(status), 2);
      check("tp_overflow_value", int'(value), 'h5678);
      key(8'h08); key("0"); key("?"); key(8'h0D);
      check("tp_backspace_value", int'(value), 'h5670);
      idle(1);

      // masked entry and cancel
      do_start(2'b11);
      key("9"); key(8'h1B);
      check("tp_cancel_status", int'(status), 4);
      check("tp_cancel_value", int'(value), 0);
      idle(2);

      // menu selection
      do_start(2'b10);
      key("c"); key("W"); key(8'h0D);
      check("tp_menu_sel", int'(menu_sel), 2);
      idle(1);
      do_start(2'b10);
      key(8'h0D);
      check("tp_menu_empty", int'(status), 3);
      key("q"); key("x"); key(8'h0D);
      idle(2);

      // timeout and key-wins-over-expiry
      do_start(2'b01);
      key("7");
      idle(TO + 5);
      check("tp_timeout_status", int'(status), 5);
      check("tp_timeout_value", int'(value), 'h7);
      do_start(2'b10);
      key("d");
      idle(TO - 1);
      key("t");
      idle(TO + 3);

      // collisions: start with ready, restart while busy, reset mid-entry
      cyc_drive(1'b1, 2'b01, 1'b1, "3");
      check("tp_collision_count", int'(digit_count), 0);
      key("4"); key("5");
      do_start(2'b11);
      key("6");
      reset_mid_entry();
      idle(3);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         int r = $urandom_range(0, 99);
         if (r < 6) cyc_drive(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rand_key());
         else if (r < 70) key(rand_key());
         else if (r < 72) idle(TO + 5);
         else idle($urandom_range(1, 3));
      end
      idle(3);

      check("echo_queue_drained", exp_echo.size(), 0);
      check("done_queue_drained", exp_done.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
